// File: rtl/wave_meas.sv
// rtl/wave_meas.sv - wave bus level, pulse-width, edge and min/max measurement peripheral
//
// Receives a 32-bit wave bus, reduces it to a level (bit 0 or an unsigned
// threshold compare) and measures high time, low time, rising edges and the
// running min/max of the raw bus. Configured and read over the native bus slave.
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   wstrb  byte write strobes, any set bit with a matching addr[31:24] is a write
//   addr   bus address, addr[31:24] block select, addr[4:2] register index
//   wdata  write data
//   rdata  read data, combinational from addr[4:2]
//   wave   waveform under measurement
module wave_meas #(
  parameter logic [7:0] ADDR_HI = 8'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] wave
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  state_t      state;
  logic        en, analog, single, valid, ovf;
  logic [31:0] thresh;
  logic [31:0] high_time, low_time, edge_cnt;
  logic [31:0] min_v, max_v;
  logic [31:0] high_cnt, low_cnt;
  logic        lvl, lvl_q, rise, fall;
  logic        wr, ctrl_wr, thresh_wr;

  // Address bits outside the block select and register index are don't-care.
  logic unused_addr;
  assign unused_addr = ^{addr[23:5], addr[1:0]};

  always_comb begin
    lvl       = analog ? (wave >= thresh) : wave[0];
    rise      = lvl & ~lvl_q;
    fall      = ~lvl & lvl_q;
    wr        = (|wstrb) && (addr[31:24] == ADDR_HI);
    ctrl_wr   = wr && (addr[4:2] == 3'd0);
    thresh_wr = wr && (addr[4:2] == 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      en        <= 1'b0;
      analog    <= 1'b0;
      single    <= 1'b0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      thresh    <= '0;
      high_time <= '0;
      low_time  <= '0;
      edge_cnt  <= '0;
      min_v     <= ALL_ONES;
      max_v     <= '0;
      high_cnt  <= '0;
      low_cnt   <= '0;
      lvl_q     <= 1'b0;
    end else begin
      lvl_q <= lvl;
      if (thresh_wr) thresh <= wdata;

      if (ctrl_wr) begin
        // A control write owns this cycle: no FSM step, no counting, a
        // coincident rise is dropped.
        en     <= wdata[0];
        analog <= wdata[1];
        single <= wdata[3];
        if (wdata[2]) begin
          high_time <= '0;
          low_time  <= '0;
          edge_cnt  <= '0;
          high_cnt  <= '0;
          low_cnt   <= '0;
          min_v     <= ALL_ONES;
          max_v     <= '0;
          valid     <= 1'b0;
          ovf       <= 1'b0;
          state     <= wdata[0] ? ARM : IDLE;
        end else if (!wdata[0]) begin
          state <= IDLE;
        end else if (state == IDLE) begin
          state <= ARM;
        end
      end else begin
        if (en) begin
          if (wave < min_v) min_v <= wave;
          if (wave > max_v) max_v <= wave;
          if (rise && (state != IDLE) && (edge_cnt != ALL_ONES))
            edge_cnt <= edge_cnt + 32'd1;
        end

        case (state)
          IDLE: ;
          ARM: begin
            if (rise) begin
              high_cnt <= 32'd1;
              low_cnt  <= '0;
              state    <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              low_cnt <= 32'd1;
              state   <= MEAS_LOW;
            end else if (high_cnt == ALL_ONES) begin
              ovf <= 1'b1;
            end else begin
              high_cnt <= high_cnt + 32'd1;
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              high_time <= high_cnt;
              low_time  <= low_cnt;
              valid     <= 1'b1;
              high_cnt  <= 32'd1;
              low_cnt   <= '0;
              if (single) begin
                state <= IDLE;
                en    <= 1'b0;
              end else begin
                state <= MEAS_HIGH;
              end
            end else if (low_cnt == ALL_ONES) begin
              ovf <= 1'b1;
            end else begin
              low_cnt <= low_cnt + 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[4:2])
      3'd0: rdata = {22'd0, ovf, valid, 2'b00, state, single, 1'b0, analog, en};
      3'd1: rdata = thresh;
      3'd2: rdata = high_time;
      3'd3: rdata = low_time;
      3'd4: rdata = edge_cnt;
      3'd5: rdata = min_v;
      3'd6: rdata = max_v;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_wave_meas.sv
// tb/tb_wave_meas.sv - scoreboard bench for wave_meas
`timescale 1ns/1ps
module tb_wave_meas;

  localparam logic [2:0] R_CTRL = 3'd0, R_THR = 3'd1, R_HI = 3'd2, R_LO = 3'd3,
                         R_EDGE = 3'd4, R_MIN = 3'd5, R_MAX = 3'd6, R_NONE = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rdata, wave;

  always #10 clk = ~clk;

  wave_meas #(.ADDR_HI(8'h05)) dut (
    .clk   (clk),
    .rst   (rst),
    .wstrb (wstrb),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .wave  (wave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [2:0]  idx;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  // Wave generator controls (written by the main process only).
  int          mode = 0;       // 0 hold, 1 pwm, 2 triangle
  int          hi_len = 1, lo_len = 1;
  int          gen_seq = 0;
  logic [31:0] hold_val = '0;

  // Wave generator: one new sample per cycle, driven at the falling edge.
  initial begin : wave_gen
    int ph;
    int last_seq;
    ph = 0;
    last_seq = 0;
    wave = '0;
    forever begin
      @(negedge clk);
      if (gen_seq != last_seq) begin
        last_seq = gen_seq;
        ph = 0;
      end
      case (mode)
        1: begin
          wave = (ph < hi_len) ? 32'd1 : 32'd0;
          ph = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
        end
        2: begin
          wave = (ph <= 40) ? ph * 100 : (80 - ph) * 100;
          ph = (ph == 79) ? 0 : ph + 1;
        end
        default: wave = hold_val;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.idx = idx;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [2:0] idx, output logic [31:0] v);
    addr = {8'h05, 19'd0, idx, 2'b00};
    #1;
    v = rdata;
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] v;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.idx, v);
      check(e.tag, v, e.exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [7:0] hi = 8'h05);
    @(negedge clk);
    addr  = {hi, 19'd0, idx, 2'b00};
    wdata = d;
    wstrb = 4'hF;
    @(negedge clk);
    wstrb = 4'h0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    logic [31:0] v;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      rd(R_CTRL, v);
      seen = v[8];
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic set_pwm(input int h, input int l);
    @(posedge clk);
    #1;
    hi_len = h;
    lo_len = l;
    mode = 1;
    gen_seq++;
  endtask

  task automatic set_hold(input logic [31:0] v);
    @(posedge clk);
    #1;
    hold_val = v;
    mode = 0;
  endtask

  task automatic set_tri();
    @(posedge clk);
    #1;
    mode = 2;
    gen_seq++;
  endtask

  initial begin : main
    logic [31:0] a, b, v;
    rst = 1'b1;
    wstrb = 4'h0;
    addr = '0;
    wdata = '0;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    // Reset values, index 7, ignored writes
    push("rst_ctrl", R_CTRL, 32'h0);
    push("rst_thr",  R_THR,  32'h0);
    push("rst_hi",   R_HI,   32'h0);
    push("rst_lo",   R_LO,   32'h0);
    push("rst_edge", R_EDGE, 32'h0);
    push("rst_min",  R_MIN,  32'hFFFF_FFFF);
    push("rst_max",  R_MAX,  32'h0);
    push("rst_idx7", R_NONE, 32'h0);
    drain();
    wr(R_HI, 32'd1234);
    wr(R_THR, 32'hDEAD_BEEF, 8'h06);
    push("ro_write_ignored", R_HI, 32'h0);
    push("other_block_ignored", R_THR, 32'h0);
    drain();

    // Square wave, half-period 5
    set_pwm(5, 5);
    cycles(3);
    wr(R_CTRL, 32'h1);
    wait_valid("sq_valid", 100);
    push("sq_hi",   R_HI,   32'd5);
    push("sq_lo",   R_LO,   32'd5);
    push("sq_ctrl", R_CTRL, 32'h121);
    push("sq_edge2", R_EDGE, 32'd2);
    drain();
    cycles(25);
    push("sq_edge4", R_EDGE, 32'd4);
    drain();

    // PWM 3/7, then 7/3
    set_pwm(3, 7);
    cycles(2);
    wr(R_CTRL, 32'h5);
    wait_valid("pwm37_valid", 100);
    push("pwm37_hi", R_HI, 32'd3);
    push("pwm37_lo", R_LO, 32'd7);
    drain();
    set_pwm(7, 3);
    cycles(35);
    push("pwm73_hi", R_HI, 32'd7);
    push("pwm73_lo", R_LO, 32'd3);
    drain();

    // Analog threshold on a triangle 0..4000 step 100
    wr(R_CTRL, 32'h4);
    wr(R_THR, 32'd2048);
    set_tri();
    wr(R_CTRL, 32'h3);
    cycles(200);
    push("tri_min", R_MIN, 32'd0);
    push("tri_max", R_MAX, 32'd4000);
    push("tri_hi",  R_HI,  32'd39);
    push("tri_lo",  R_LO,  32'd41);
    drain();
    rd(R_HI, a);
    rd(R_LO, b);
    check("tri_period", a + b, 32'd80);

    // Single shot
    wr(R_CTRL, 32'h4);
    set_pwm(5, 5);
    wr(R_CTRL, 32'h9);
    wait_valid("single_valid", 100);
    push("single_hi",   R_HI,   32'd5);
    push("single_lo",   R_LO,   32'd5);
    push("single_ctrl", R_CTRL, 32'h108);
    push("single_edge", R_EDGE, 32'd2);
    drain();
    cycles(40);
    push("single_hi_hold",   R_HI,   32'd5);
    push("single_lo_hold",   R_LO,   32'd5);
    push("single_edge_hold", R_EDGE, 32'd2);
    drain();

    // Level held high: results hold, forced counter saturation sets OVF
    wr(R_CTRL, 32'h4);
    set_pwm(5, 5);
    wr(R_CTRL, 32'h1);
    wait_valid("hold_valid0", 100);
    set_hold(32'd1);
    cycles(30);
    push("hold_hi",   R_HI,   32'd5);
    push("hold_ctrl", R_CTRL, 32'h121);
    drain();
    force dut.high_cnt = 32'hFFFF_FFFF;
    cycles(3);
    release dut.high_cnt;
    cycles(1);
    rd(R_CTRL, v);
    check("ovf_set", {31'd0, v[9]}, 32'd1);

    // Clear with EN: sampled before the next edge can update MIN/MAX
    wr(R_CTRL, 32'h5);
    push("clr_min",  R_MIN,  32'hFFFF_FFFF);
    push("clr_max",  R_MAX,  32'h0);
    push("clr_ctrl", R_CTRL, 32'h11);
    push("clr_hi",   R_HI,   32'h0);
    drain();
    push("clr_lo",   R_LO,   32'h0);
    push("clr_edge", R_EDGE, 32'h0);
    drain();

    // Control write coincident with a rise drops that rise
    wr(R_CTRL, 32'h4);
    set_hold(32'd0);
    cycles(2);
    wr(R_CTRL, 32'h1);
    @(posedge clk);
    #1;
    hold_val = 32'd1;
    wr(R_CTRL, 32'h1);
    cycles(3);
    push("coinc_edge", R_EDGE, 32'd0);
    push("coinc_ctrl", R_CTRL, 32'h11);
    drain();
    set_hold(32'd0);
    cycles(2);
    set_hold(32'd1);
    cycles(2);
    push("after_edge", R_EDGE, 32'd1);
    push("after_ctrl", R_CTRL, 32'h21);
    drain();

    // Reset in the middle of MEAS_LOW
    wr(R_CTRL, 32'h4);
    wr(R_THR, 32'd77);
    set_pwm(5, 5);
    wr(R_CTRL, 32'h1);
    wait_valid("mrst_valid", 100);
    cycles(6);
    push("mrst_state", R_CTRL, 32'h131);
    drain();
    rst = 1'b1;
    cycles(1);
    push("mrst_ctrl", R_CTRL, 32'h0);
    push("mrst_thr",  R_THR,  32'h0);
    push("mrst_hi",   R_HI,   32'h0);
    push("mrst_lo",   R_LO,   32'h0);
    push("mrst_edge", R_EDGE, 32'h0);
    push("mrst_min",  R_MIN,  32'hFFFF_FFFF);
    push("mrst_max",  R_MAX,  32'h0);
    drain();
    rst = 1'b0;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wave_meas.md
Name: wave_meas

Overview:
Memory-mapped PicoSoC peripheral that is the receive end of the waveform generator's `wave` output. It samples a 32-bit wave bus and turns it into a level, either bit 0 or a threshold compare. From that level it measures high time, low time, rising-edge count, and running min/max. Firmware configures it and reads results over the same native bus slave interface as the generator, decoded at `addr[31:24] == 8'h05`.

Parameters:
- ADDR_HI, 8'h05, value of `addr[31:24]` that selects this block.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- wstrb  in  4  byte write strobes; a write occurs when `|wstrb` and `addr[31:24] == ADDR_HI`.
- addr  in  32  bus address; `addr[4:2]` selects the register.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from `addr[4:2]`.
- wave  in  32  waveform under measurement; registered upstream.

Behaviour:
- Register map (`addr[4:2]`):
  - 0 CTRL (RW): bit0 EN, bit1 ANALOG, bit2 CLR (write-only, self-clearing, reads 0), bit3 SINGLE. Read-only status: bits5:4 state, bit8 VALID, bit9 OVF.
  - 1 THRESH (RW, 32 bits).
  - 2 HIGH_TIME (RO).
  - 3 LOW_TIME (RO).
  - 4 EDGE_CNT (RO).
  - 5 MIN (RO).
  - 6 MAX (RO).
  - 7 reads 0.
  - Writes to RO registers or to index 7 are ignored. Unused rdata bits read 0.
- Level:
  - `lvl = ANALOG ? (wave >= THRESH, unsigned) : wave[0]`.
  - `lvl_q` is registered every cycle unconditionally.
  - `rise = lvl & ~lvl_q`; `fall = ~lvl & lvl_q`.
- FSM states, encoded in CTRL bits5:4: IDLE=0, ARM=1, MEAS_HIGH=2, MEAS_LOW=3.
  - IDLE: leaves when EN is written 1; goes to ARM on the next cycle.
  - ARM: on `rise`, set `high_cnt<=1`, `low_cnt<=0`, go to MEAS_HIGH.
  - MEAS_HIGH: on `fall`, set `low_cnt<=1`, go to MEAS_LOW; otherwise `high_cnt+1`.
  - MEAS_LOW: on `rise`, load `HIGH_TIME<=high_cnt` and `LOW_TIME<=low_cnt`, set VALID=1, `high_cnt<=1`, `low_cnt<=0`. Then go to MEAS_HIGH, or to IDLE with EN<=0 if SINGLE=1. Otherwise `low_cnt+1`.
  - Any state: a write with EN=0 forces IDLE on the next cycle. Results and VALID hold.
- Latency: results and VALID are visible the cycle after the cycle in which `wave` first presents the new high level.
- Counters:
  - `high_cnt`, `low_cnt` and EDGE_CNT are 32-bit and saturate at 32'hFFFFFFFF.
  - A saturation of `high_cnt` or `low_cnt` sets OVF (sticky).
  - EDGE_CNT increments on every `rise` while EN=1, in any non-IDLE state.
- MIN/MAX: while EN=1, every cycle `MIN<=min(MIN,wave)` and `MAX<=max(MAX,wave)`, unsigned full 32-bit compare.
- CLR (write with bit2=1):
  - HIGH_TIME, LOW_TIME, EDGE_CNT, `high_cnt`, `low_cnt` <= 0; MIN<=32'hFFFFFFFF; MAX<=0; VALID<=0; OVF<=0.
  - State <= ARM if the written EN=1, else IDLE.
  - EN, ANALOG and SINGLE are taken from the same write.
- Write priority:
  - A CTRL write overrides FSM and measurement updates in the same cycle; a `rise` coincident with the write is ignored.
  - A THRESH write takes effect for `lvl` from the next cycle.
- Reset: all registers and the state go to IDLE/0, except MIN=32'hFFFFFFFF; `lvl_q`<=0. rdata then follows the register contents. Reset mid-measurement discards partial counts.

Test Plan:
- Generator-style TOGGLE with half-period 5 (`wave[0]` toggles every 5 cycles), write CTRL=1 -> after the second rise, HIGH_TIME=5, LOW_TIME=5, VALID=1, state=MEAS_HIGH. After 4 rises, EDGE_CNT=4.
- PWM at 3 cycles high / 7 cycles low, CTRL=1 -> HIGH_TIME=3, LOW_TIME=7. Reprogram to 7 high / 3 low -> HIGH_TIME=7, LOW_TIME=3 after one full new period.
- ANALOG=1, THRESH=2048, triangle 0..4000 in steps of 100 (41-cycle ramps), CTRL=3 -> MIN=0, MAX=4000; HIGH_TIME+LOW_TIME equals the triangle period of 80 cycles.
- SINGLE: CTRL=9 with the square wave from test 1 -> one result latched (5/5), then state=IDLE and EN reads 0. Later edges leave HIGH_TIME, LOW_TIME and EDGE_CNT unchanged.
- Edge cases, four sub-checks:
  - Hold `wave[0]=1` after a rise -> HIGH_TIME unchanged, VALID unchanged; with the counter preloaded near 32'hFFFFFFFF (force), OVF=1.
  - Write CTRL=5 -> all results cleared, MIN=FFFFFFFF, state=ARM.
  - A CTRL write coincident with a rise -> that rise is not counted.
  - Assert `rst` mid-MEAS_LOW -> all outputs at reset values the next cycle.
